// File: rtl/latch_gate_sched.sv
`default_nettype none
// ============================================================================
// Module   : latch_gate_sched
// Purpose  : Sequences a level-sensitive latch gate and the data line that
//            feeds it. The data is frozen for SETUP cycles before the gate
//            rises, for the GATE_W cycles the gate is high, and for HOLD
//            cycles after the gate falls. This makes the latch setup/hold
//            no-change window safe by construction. Protocol errors from the
//            valid/ready update source are also flagged.
// Ports    : clk          - clock, all logic on rising edge
//            rst          - asynchronous active-high reset
//            upd_valid_i  - update request for the latch data
//            upd_data_i   - new data value
//            upd_ready_o  - update accepted when valid && ready (IDLE only)
//            gate_req_i   - level request for one gate pulse
//            d_o          - registered data to the latch D input
//            gate_o       - registered latch enable
//            busy_o       - high whenever a window is in progress
//            gate_done_o  - one-cycle pulse in the last cycle of the window
//            err_o        - sticky protocol-error flag
// Revision : 1.0 - initial release
// ============================================================================
module latch_gate_sched #(
    parameter int DW     = 8,
    parameter int SETUP  = 2,
    parameter int GATE_W = 4,
    parameter int HOLD   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          upd_valid_i,
    input  logic [DW-1:0] upd_data_i,
    output logic          upd_ready_o,
    input  logic          gate_req_i,
    output logic [DW-1:0] d_o,
    output logic          gate_o,
    output logic          busy_o,
    output logic          gate_done_o,
    output logic          err_o
);

    // A zero-width gate pulse is meaningless; refuse to elaborate.
    if (GATE_W < 1) begin : g_bad_gate_w
        $error("latch_gate_sched: GATE_W must be >= 1");
    end

    // Counter sized for the longest of the three phases.
    localparam int c_MAX_SG = (SETUP > GATE_W) ? SETUP : GATE_W;
    localparam int c_MAXV   = (c_MAX_SG > HOLD) ? c_MAX_SG : HOLD;
    localparam int c_CW     = $clog2(c_MAXV + 1);

    // The counter is loaded with (phase length - 1) and the phase ends when it reads 0.
    localparam logic [c_CW-1:0] c_SETUP_LD = c_CW'((SETUP > 0) ? SETUP - 1 : 0);
    localparam logic [c_CW-1:0] c_GATE_LD  = c_CW'(GATE_W - 1);
    localparam logic [c_CW-1:0] c_HOLD_LD  = c_CW'((HOLD > 0) ? HOLD - 1 : 0);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_GATE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            gate_q, gate_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            stall_q;      // previous cycle had valid && !ready
    logic [DW-1:0]   prev_data_q;  // upd_data_i seen in the previous cycle

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                // Data may only change here; a simultaneous gate request
                // treats the freshly loaded value as stable from this edge.
                if (upd_valid_i) begin
                    data_d = upd_data_i;
                end
                if (gate_req_i) begin
                    if (SETUP > 0) begin
                        state_d = S_SETUP;
                        cnt_d   = c_SETUP_LD;
                    end else begin
                        state_d = S_GATE;
                        cnt_d   = c_GATE_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_GATE;
                    cnt_d   = c_GATE_LD;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_GATE: begin
                if (cnt_q == '0) begin
                    if (HOLD > 0) begin
                        state_d = S_HOLD;
                        cnt_d   = c_HOLD_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - c_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered
        // in exactly the cycle the state is entered.
        gate_d = (state_d == S_GATE);
        done_d = (cnt_d == '0) &&
                 ((state_d == S_HOLD) || ((state_d == S_GATE) && (HOLD == 0)));

        // A stalled offer must keep its data and must not be withdrawn.
        err_d = err_q | (stall_q && (!upd_valid_i || (upd_data_i != prev_data_q)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            gate_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            prev_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            gate_q      <= gate_d;
            done_q      <= done_d;
            err_q       <= err_d;
            stall_q     <= upd_valid_i && !upd_ready_o;
            prev_data_q <= upd_data_i;
        end
    end

    assign upd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign d_o         = data_q;
    assign gate_o      = gate_q;
    assign gate_done_o = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire
